deflect_port_alloc: RTL and testbench

DEFLECT_PORT_ALLOC -- requirements
Module: deflect_port_alloc

---
 rtl/deflect_port_alloc_if.sv | 30 +++
 rtl/deflect_port_alloc.sv | 164 ++++++++++++++++
 tb/tb_deflect_port_alloc.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/deflect_port_alloc_if.sv
// rtl/deflect_port_alloc_if.sv - network, injection and ejection signals of the deflection allocator
interface deflect_port_alloc_if #(
  parameter int FLIT_W = 64,
  parameter int AGE_W  = 8
);
  logic [3:0]          in_valid;
  logic [4*FLIT_W-1:0] in_flit;
  logic [4*AGE_W-1:0]  in_age;
  logic [19:0]         in_prod;
  logic                inj_valid;
  logic [FLIT_W-1:0]   inj_flit;
  logic [4:0]          inj_prod;
  logic                inj_ready;
  logic [3:0]          out_valid;
  logic [4*FLIT_W-1:0] out_flit;
  logic [4*AGE_W-1:0]  out_age;
  logic                ej_valid;
  logic [FLIT_W-1:0]   ej_flit;
  logic [15:0]         defl_cnt;

  modport master (
    output in_valid, in_flit, in_age, in_prod, inj_valid, inj_flit, inj_prod,
    input  inj_ready, out_valid, out_flit, out_age, ej_valid, ej_flit, defl_cnt
  );

  modport slave (
    input  in_valid, in_flit, in_age, in_prod, inj_valid, inj_flit, inj_prod,
    output inj_ready, out_valid, out_flit, out_age, ej_valid, ej_flit, defl_cnt
  );
endinterface

// File: rtl/deflect_port_alloc.sv
// rtl/deflect_port_alloc.sv - two-stage age-ordered deflection port allocator with local inject/eject
module deflect_port_alloc #(
  parameter int FLIT_W = 64,
  parameter int AGE_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  deflect_port_alloc_if.slave  bus
);

  logic [3:0]          r_s1_valid;
  logic [4*FLIT_W-1:0] r_s1_flit;
  logic [4*AGE_W-1:0]  r_s1_age;
  logic [19:0]         r_s1_prod;
  logic [1:0]          r_rr_ptr;
  logic [3:0]          r_out_valid;
  logic [4*FLIT_W-1:0] r_out_flit;
  logic [4*AGE_W-1:0]  r_out_age;
  logic                r_ej_valid;
  logic [FLIT_W-1:0]   r_ej_flit;
  logic [15:0]         r_defl_cnt;

  logic [1:0]          w_dist [4];
  logic [1:0]          w_rank [4];
  logic [3:0]          w_free;
  logic [3:0]          w_hit;
  logic [4:0]          w_prod;
  logic [1:0]          w_port;
  logic [AGE_W-1:0]    w_age;
  logic [3:0]          w_nxt_valid;
  logic [4*FLIT_W-1:0] w_nxt_flit;
  logic [4*AGE_W-1:0]  w_nxt_age;
  logic                w_nxt_ej_valid;
  logic [FLIT_W-1:0]   w_nxt_ej_flit;
  logic [2:0]          w_defl_num;
  logic                w_inj_ready;
  logic [16:0]         w_defl_sum;
  logic                w_inj_unused;

  // The Local bit of the injection vector is meaningless: injections never eject.
  assign w_inj_unused = bus.inj_prod[4];

  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int b = 3; b >= 0; b--) begin
      if (m[b]) lowest = 2'(b);
    end
  endfunction

  function automatic logic beats(input logic [AGE_W-1:0] age_a, input logic [1:0] d_a,
                                 input logic [AGE_W-1:0] age_b, input logic [1:0] d_b);
    beats = (age_a > age_b) || ((age_a == age_b) && (d_a < d_b));
  endfunction

  // Rank = number of valid flits that outrank this one; ranks are unique because distances are.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_dist[i] = 2'(i) - r_rr_ptr;
    end
    for (int i = 0; i < 4; i++) begin
      w_rank[i] = 2'd0;
      for (int j = 0; j < 4; j++) begin
        if (j != i && r_s1_valid[j] &&
            beats(r_s1_age[j*AGE_W +: AGE_W], w_dist[j], r_s1_age[i*AGE_W +: AGE_W], w_dist[i]))
          w_rank[i] = w_rank[i] + 2'd1;
      end
    end
  end

  always_comb begin
    w_free         = 4'hF;
    w_hit          = 4'h0;
    w_prod         = 5'd0;
    w_port         = 2'd0;
    w_age          = '0;
    w_nxt_valid    = 4'h0;
    w_nxt_flit     = '0;
    w_nxt_age      = '0;
    w_nxt_ej_valid = 1'b0;
    w_nxt_ej_flit  = '0;
    w_defl_num     = 3'd0;
    w_inj_ready    = 1'b0;

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (r_s1_valid[i] && w_rank[i] == 2'(k)) begin
          w_prod = r_s1_prod[i*5 +: 5];
          w_age  = r_s1_age[i*AGE_W +: AGE_W];
          if (w_prod[4] && !w_nxt_ej_valid) begin
            w_nxt_ej_valid = 1'b1;
            w_nxt_ej_flit  = r_s1_flit[i*FLIT_W +: FLIT_W];
          end else begin
            w_hit = w_free & w_prod[3:0];
            if (|w_hit) begin
              w_port = lowest(w_hit);
            end else begin
              w_port     = lowest(w_free);
              w_defl_num = w_defl_num + 3'd1;
            end
            w_free[w_port]                        = 1'b0;
            w_nxt_valid[w_port]                   = 1'b1;
            w_nxt_flit[w_port*FLIT_W +: FLIT_W]   = r_s1_flit[i*FLIT_W +: FLIT_W];
            w_nxt_age[w_port*AGE_W +: AGE_W]      = (&w_age) ? w_age : w_age + 1'b1;
          end
        end
      end
    end

    // Injection takes whatever network port survives the S1 flits, always with age 0.
    w_inj_ready = rst_n && (|w_free);
    if (bus.inj_valid && w_inj_ready) begin
      w_hit = w_free & bus.inj_prod[3:0];
      if (|w_hit) begin
        w_port = lowest(w_hit);
      end else begin
        w_port     = lowest(w_free);
        w_defl_num = w_defl_num + 3'd1;
      end
      w_free[w_port]                      = 1'b0;
      w_nxt_valid[w_port]                 = 1'b1;
      w_nxt_flit[w_port*FLIT_W +: FLIT_W] = bus.inj_flit;
      w_nxt_age[w_port*AGE_W +: AGE_W]    = '0;
    end
  end

  assign w_defl_sum = {1'b0, r_defl_cnt} + 17'(w_defl_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 4'h0;
      r_s1_flit   <= '0;
      r_s1_age    <= '0;
      r_s1_prod   <= '0;
      r_rr_ptr    <= 2'd0;
      r_out_valid <= 4'h0;
      r_out_flit  <= '0;
      r_out_age   <= '0;
      r_ej_valid  <= 1'b0;
      r_ej_flit   <= '0;
      r_defl_cnt  <= 16'd0;
    end else begin
      r_s1_valid  <= bus.in_valid;
      r_s1_flit   <= bus.in_flit;
      r_s1_age    <= bus.in_age;
      r_s1_prod   <= bus.in_prod;
      r_rr_ptr    <= r_rr_ptr + 2'(|r_s1_valid);
      r_out_valid <= w_nxt_valid;
      r_out_flit  <= w_nxt_flit;
      r_out_age   <= w_nxt_age;
      r_ej_valid  <= w_nxt_ej_valid;
      r_ej_flit   <= w_nxt_ej_flit;
      r_defl_cnt  <= w_defl_sum[16] ? 16'hFFFF : w_defl_sum[15:0];
    end
  end

  assign bus.inj_ready = w_inj_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_flit  = r_out_flit;
  assign bus.out_age   = r_out_age;
  assign bus.ej_valid  = r_ej_valid;
  assign bus.ej_flit   = r_ej_flit;
  assign bus.defl_cnt  = r_defl_cnt;

endmodule

// File: tb/tb_deflect_port_alloc.sv
// tb/tb_deflect_port_alloc.sv - directed self-checking bench for deflect_port_alloc
module tb_deflect_port_alloc;
  localparam int FW = 64;
  localparam int AW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] exp_defl = 16'd0;

  deflect_port_alloc_if #(.FLIT_W(FW), .AGE_W(AW)) bus ();
  deflect_port_alloc #(.FLIT_W(FW), .AGE_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] oflit(input int p);
    return bus.out_flit[p*FW +: FW];
  endfunction

  function automatic logic [AW-1:0] oage(input int p);
    return bus.out_age[p*AW +: AW];
  endfunction

  function automatic logic [FW-1:0] fl(input int i);
    return 64'hF1_7000_0000_0000 + 64'(i);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in;
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.in_age    = '0;
    bus.in_prod   = '0;
    bus.inj_valid = 1'b0;
    bus.inj_flit  = '0;
    bus.inj_prod  = '0;
  endtask

  task automatic set_flit(input int i, input logic [FW-1:0] f, input logic [AW-1:0] a, input logic [4:0] p);
    bus.in_valid[i]         = 1'b1;
    bus.in_flit[i*FW +: FW] = f;
    bus.in_age[i*AW +: AW]  = a;
    bus.in_prod[i*5 +: 5]   = p;
  endtask

  task automatic do_reset;
    clear_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_defl = 16'd0;
  endtask

  task automatic test_reset;
    clear_in();
    #1 rst_n = 1'b0;
    bus.inj_valid = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid); end
    checks++; if (bus.ej_valid !== 1'b0) begin errors++; $display("FAIL reset_ej_valid: got %b want 0", bus.ej_valid); end
    checks++; if (bus.defl_cnt !== 16'h0) begin errors++; $display("FAIL reset_defl: got %h want 0000", bus.defl_cnt); end
    checks++; if (bus.inj_ready !== 1'b0) begin errors++; $display("FAIL reset_inj_ready: got %b want 0", bus.inj_ready); end
    bus.inj_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_east;
    clear_in();
    set_flit(0, fl(10), 8'd5, 5'b00010);
    step();
    clear_in();
    step();
    checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("FAIL single_valid: got %b want 0010", bus.out_valid); end
    checks++; if (oage(1) !== 8'd6) begin errors++; $display("FAIL single_age: got %0d want 6", oage(1)); end
    checks++; if (oflit(1) !== fl(10)) begin errors++; $display("FAIL single_flit: got %h want %h", oflit(1), fl(10)); end
    checks++; if (bus.defl_cnt !== exp_defl) begin errors++; $display("FAIL single_defl: got %h want %h", bus.defl_cnt, exp_defl); end
  endtask

  task automatic test_eject_contention;
    clear_in();
    set_flit(0, fl(20), 8'd9, 5'b10000);
    set_flit(1, fl(21), 8'd3, 5'b10000);
    step();
    clear_in();
    step();
    exp_defl = exp_defl + 16'd1;
    checks++; if (bus.ej_valid !== 1'b1 || bus.ej_flit !== fl(20)) begin errors++; $display("FAIL eject_winner: got v=%b %h want v=1 %h", bus.ej_valid, bus.ej_flit, fl(20)); end
    checks++; if (bus.out_valid !== 4'b0001 || oflit(0) !== fl(21)) begin errors++; $display("FAIL eject_loser: got %b %h want 0001 %h", bus.out_valid, oflit(0), fl(21)); end
    checks++; if (oage(0) !== 8'd4) begin errors++; $display("FAIL eject_loser_age: got %0d want 4", oage(0)); end
    checks++; if (bus.defl_cnt !== exp_defl) begin errors++; $display("FAIL eject_defl: got %h want %h", bus.defl_cnt, exp_defl); end
  endtask

  task automatic test_round_robin;
    do_reset();
    set_flit(1, fl(30), 8'd1, 5'b00010);
    step();
    step();
    clear_in();
    for (int i = 0; i < 4; i++) set_flit(i, fl(40 + i), 8'd7, 5'b01000);
    step();
    clear_in();
    bus.inj_valid = 1'b1;
    bus.inj_flit  = fl(99);
    bus.inj_prod  = 5'b00001;
    #1;
    checks++; if (bus.inj_ready !== 1'b0) begin errors++; $display("FAIL rr_inj_ready: got %b want 0", bus.inj_ready); end
    step();
    clear_in();
    exp_defl = exp_defl + 16'd3;
    checks++; if (bus.out_valid !== 4'b1111) begin errors++; $display("FAIL rr_valid: got %b want 1111", bus.out_valid); end
    checks++; if (oflit(3) !== fl(42)) begin errors++; $display("FAIL rr_north: got %h want %h", oflit(3), fl(42)); end
    checks++; if (oflit(0) !== fl(43) || oflit(1) !== fl(40) || oflit(2) !== fl(41)) begin
      errors++; $display("FAIL rr_deflected: got %h %h %h want %h %h %h", oflit(0), oflit(1), oflit(2), fl(43), fl(40), fl(41));
    end
    checks++; if (bus.defl_cnt !== exp_defl) begin errors++; $display("FAIL rr_defl: got %h want %h", bus.defl_cnt, exp_defl); end
  endtask

  task automatic test_inject;
    clear_in();
    set_flit(0, fl(50), 8'd4, 5'b00001);
    set_flit(1, fl(51), 8'd4, 5'b00010);
    set_flit(3, fl(53), 8'd4, 5'b01000);
    step();
    clear_in();
    bus.inj_valid = 1'b1;
    bus.inj_flit  = fl(55);
    bus.inj_prod  = 5'b00001;
    #1;
    checks++; if (bus.inj_ready !== 1'b1) begin errors++; $display("FAIL inj_ready: got %b want 1", bus.inj_ready); end
    step();
    clear_in();
    exp_defl = exp_defl + 16'd1;
    checks++; if (bus.out_valid !== 4'b1111) begin errors++; $display("FAIL inj_valid_out: got %b want 1111", bus.out_valid); end
    checks++; if (oflit(2) !== fl(55) || oage(2) !== 8'd0) begin errors++; $display("FAIL inj_port: got %h age %0d want %h age 0", oflit(2), oage(2), fl(55)); end
    checks++; if (oflit(0) !== fl(50) || oage(0) !== 8'd5) begin errors++; $display("FAIL inj_west: got %h age %0d want %h age 5", oflit(0), oage(0), fl(50)); end
    checks++; if (bus.defl_cnt !== exp_defl) begin errors++; $display("FAIL inj_defl: got %h want %h", bus.defl_cnt, exp_defl); end
  endtask

  task automatic test_inject_alone;
    clear_in();
    bus.inj_valid = 1'b1;
    bus.inj_flit  = fl(60);
    bus.inj_prod  = 5'b00100;
    #1;
    checks++; if (bus.inj_ready !== 1'b1) begin errors++; $display("FAIL inj_alone_ready: got %b want 1", bus.inj_ready); end
    step();
    clear_in();
    checks++; if (bus.out_valid !== 4'b0100 || oflit(2) !== fl(60)) begin errors++; $display("FAIL inj_alone_out: got %b %h want 0100 %h", bus.out_valid, oflit(2), fl(60)); end
    checks++; if (bus.defl_cnt !== exp_defl) begin errors++; $display("FAIL inj_alone_defl: got %h want %h", bus.defl_cnt, exp_defl); end
  endtask

  task automatic test_zero_prod_age_sat;
    clear_in();
    set_flit(2, fl(70), 8'd255, 5'b00000);
    set_flit(0, fl(71), 8'd0, 5'b00001);
    step();
    clear_in();
    step();
    exp_defl = exp_defl + 16'd2;
    checks++; if (bus.out_valid !== 4'b0011) begin errors++; $display("FAIL zp_valid: got %b want 0011", bus.out_valid); end
    checks++; if (oflit(0) !== fl(70) || oage(0) !== 8'd255) begin errors++; $display("FAIL zp_sat: got %h age %0d want %h age 255", oflit(0), oage(0), fl(70)); end
    checks++; if (oflit(1) !== fl(71) || oage(1) !== 8'd1) begin errors++; $display("FAIL zp_young: got %h age %0d want %h age 1", oflit(1), oage(1), fl(71)); end
    checks++; if (bus.out_flit[2*FW +: 2*FW] !== '0 || bus.out_age[2*AW +: 2*AW] !== '0) begin errors++; $display("FAIL zp_idle_zero: got %h %h want 0", bus.out_flit[2*FW +: 2*FW], bus.out_age[2*AW +: 2*AW]); end
    checks++; if (bus.defl_cnt !== exp_defl) begin errors++; $display("FAIL zp_defl: got %h want %h", bus.defl_cnt, exp_defl); end
  endtask

  task automatic test_reset_mid;
    clear_in();
    set_flit(0, fl(80), 8'd1, 5'b10000);
    set_flit(1, fl(81), 8'd1, 5'b00010);
    step();
    step();
    checks++; if (bus.ej_valid !== 1'b1 || bus.out_valid !== 4'b0010) begin errors++; $display("FAIL mid_pre: got ej=%b out=%b want ej=1 out=0010", bus.ej_valid, bus.out_valid); end
    rst_n = 1'b0;
    bus.inj_valid = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 4'h0 || bus.ej_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got out=%b ej=%b want 0", bus.out_valid, bus.ej_valid); end
    checks++; if (bus.out_flit !== '0 || bus.out_age !== '0 || bus.ej_flit !== '0) begin errors++; $display("FAIL mid_data: got nonzero %h want 0", bus.ej_flit); end
    checks++; if (bus.defl_cnt !== 16'h0 || bus.inj_ready !== 1'b0) begin errors++; $display("FAIL mid_cnt: got %h ready=%b want 0000 ready=0", bus.defl_cnt, bus.inj_ready); end
    clear_in();
    step();
    rst_n = 1'b1;
    exp_defl = 16'd0;
    step();
    step();
    checks++; if (bus.out_valid !== 4'h0 || bus.ej_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: got out=%b ej=%b want 0", bus.out_valid, bus.ej_valid); end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i < 4; i++) set_flit(i, fl(90 + i), 8'd2, 5'b00000);
    for (int n = 0; n < 16383; n++) step();
    clear_in();
    set_flit(0, fl(95), 8'd2, 5'b00000);
    set_flit(1, fl(96), 8'd2, 5'b00000);
    step();
    clear_in();
    step();
    step();
    checks++; if (bus.defl_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", bus.defl_cnt); end
    for (int i = 0; i < 3; i++) set_flit(i, fl(97 + i), 8'd2, 5'b00000);
    step();
    clear_in();
    step();
    checks++; if (bus.defl_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h want ffff", bus.defl_cnt); end
    for (int i = 0; i < 4; i++) set_flit(i, fl(100 + i), 8'd2, 5'b00000);
    step();
    clear_in();
    step();
    checks++; if (bus.defl_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", bus.defl_cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_east();
    test_eject_contention();
    test_round_robin();
    test_inject();
    test_inject_alone();
    test_zero_prod_age_sat();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
